qed_dup_sequencer: RTL

Producer-side counterpart to the instruction legality constraint. It sits between the fetch output and the RIDECORE decode input. Legal "original" instructions (architectural registers x0–x15, memory words below 1024) pass through and are buffered. The block then replays each buffered instruction as its EDDI-V duplicate, which uses registers x16–x31 and memory words 1024 and above. Final architectural state can then be compared original-vs-duplicate for QED checking.

---
 rtl/qed_pkg.sv | 16 +
 rtl/qed_dup_xform.sv | 34 +++
 rtl/qed_dup_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - opcode constants, QED bit positions and sequencer state type
package qed_pkg;

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_NOP   = 7'h7F;

    // Duplicates live in x16-x31 and in memory words at 1024 and above
    localparam int QED_REG_BIT = 4;
    localparam int QED_MEM_BIT = 30;

    typedef enum logic {ORIG, DUP} qed_state_t;

endpackage

// File: rtl/qed_dup_xform.sv
// rtl/qed_dup_xform.sv - combinational map from an original instruction to its EDDI-V duplicate
module qed_dup_xform
    import qed_pkg::*;
(
    input  logic [31:0] orig,
    output logic [31:0] dup
);

    // rd at [11:7], rs1 at [19:15], rs2 at [24:20]; rs1 of LW/SW is x0 and stays x0
    always_comb begin
        dup = orig;
        case (orig[6:0])
            OP_ALU_R: begin
                dup[7 + QED_REG_BIT]  = 1'b1;
                dup[15 + QED_REG_BIT] = 1'b1;
                dup[20 + QED_REG_BIT] = 1'b1;
            end
            OP_ALU_I: begin
                dup[7 + QED_REG_BIT]  = 1'b1;
                dup[15 + QED_REG_BIT] = 1'b1;
            end
            OP_LOAD: begin
                dup[7 + QED_REG_BIT] = 1'b1;
                dup[QED_MEM_BIT]     = 1'b1;
            end
            OP_STORE: begin
                dup[20 + QED_REG_BIT] = 1'b1;
                dup[QED_MEM_BIT]      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qed_dup_sequencer.sv
// rtl/qed_dup_sequencer.sv - buffers QED originals and replays them as duplicates; QED_ASSERT_EN adds checks
module qed_dup_sequencer
    import qed_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     exec_dup,
    input  logic [31:0]              ifu_inst,
    input  logic                     ifu_valid,
    input  logic                     stall,
    output logic                     ifu_ready,
    output logic [31:0]              qed_inst,
    output logic                     qed_valid,
    output logic                     dup_phase,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    qed_state_t     state, state_next;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [31:0]    dup_inst;
    logic [31:0]    out_inst;
    logic           out_valid;
    logic [CW-1:0]  count_next;
    logic           is_nop, push, pop, flush;

    qed_dup_xform u_xform (
        .orig (mem[rd_ptr]),
        .dup  (dup_inst)
    );

    always_comb begin
        ifu_ready  = !stall && (state == ORIG || !ena);
        is_nop     = (ifu_inst[6:0] == OP_NOP);
        push       = 1'b0;
        pop        = 1'b0;
        flush      = !ena;
        state_next = state;
        count_next = q_count;
        out_inst   = qed_inst;
        out_valid  = qed_valid;
        if (!ena) begin
            // Pass-through mode; the flush applies even while stalled
            state_next = ORIG;
            count_next = '0;
            if (!stall) begin
                out_inst  = ifu_inst;
                out_valid = ifu_valid && !is_nop;
            end
        end else if (!stall) begin
            case (state)
                ORIG: begin
                    if (ifu_valid && !is_nop) begin
                        push      = 1'b1;
                        out_inst  = ifu_inst;
                        out_valid = 1'b1;
                    end else begin
                        out_valid = 1'b0;
                    end
                    count_next = q_count + CW'(push);
                    if ((push && count_next == CW'(DEPTH)) || (exec_dup && count_next != '0))
                        state_next = DUP;
                end
                DUP: begin
                    if (q_count != '0) begin
                        pop        = 1'b1;
                        out_inst   = dup_inst;
                        out_valid  = 1'b1;
                        count_next = q_count - 1'b1;
                        if (count_next == '0)
                            state_next = ORIG;
                    end else begin
                        out_valid  = 1'b0;
                        state_next = ORIG;
                    end
                end
                default: state_next = ORIG;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ORIG;
            q_count   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            qed_inst  <= 32'h0;
            qed_valid <= 1'b0;
            dup_phase <= 1'b0;
        end else begin
            state     <= state_next;
            q_count   <= count_next;
            qed_inst  <= out_inst;
            qed_valid <= out_valid;
            dup_phase <= (state == DUP);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ifu_inst;
    end

`ifdef QED_ASSERT_EN
    always @(posedge clk) begin
        if (!rst) begin
            assert (q_count <= CW'(DEPTH));
            assert (!(pop && q_count == '0));
            if (pop && (dup_inst[6:0] == OP_ALU_R || dup_inst[6:0] == OP_ALU_I ||
                        dup_inst[6:0] == OP_LOAD))
                assert (dup_inst[7 + QED_REG_BIT]);
            if (pop && (dup_inst[6:0] == OP_LOAD || dup_inst[6:0] == OP_STORE))
                assert (dup_inst[QED_MEM_BIT]);
        end
    end
`else
`endif

endmodule
